// File: rtl/num_conv_pkg.sv
// Shared types, constants and helpers for the character/binary converter.
package num_conv_pkg;

    localparam int unsigned CODE_W         = 6;
    localparam int unsigned NCHAR_DEF      = 10;
    localparam int unsigned WORD_W_DEF     = 30;
    localparam int unsigned DIGIT_BASE_DEF = 30;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        NUM_RUN  = 2'd1,
        CHAR_RUN = 2'd2,
        FINISH   = 2'd3
    } state_e;

    localparam logic MODE_NUM  = 1'b0;
    localparam logic MODE_CHAR = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Step counter width large enough for either conversion length.
    function automatic int unsigned cnt_w(input int unsigned n, input int unsigned w);
        return $clog2(max_u(n, w) + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_w(NCHAR_DEF, WORD_W_DEF);

    function automatic logic [3:0] mod10(input logic [CODE_W-1:0] code);
        return 4'(code % CODE_W'(10));
    endfunction

endpackage

// File: rtl/num_char_conv_bcd_add3.sv
// One double-dabble correction cell: a BCD digit gets +3 when it is 5 or more.
// Only built when NUM_CHAR_CONV_CHAR_EN is defined.
`ifdef NUM_CHAR_CONV_CHAR_EN
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_c
);

    assign digit_c = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule
`endif

// File: rtl/num_char_conv.sv
// Multi-cycle converter between character-coded decimal fields and binary words.
// Define NUM_CHAR_CONV_CHAR_EN to build CHAR mode (binary -> characters).
module num_char_conv
    import num_conv_pkg::*;
#(
    parameter int unsigned NCHAR      = NCHAR_DEF,
    parameter int unsigned BYTE_W     = CODE_W,
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned DIGIT_BASE = DIGIT_BASE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [NCHAR*BYTE_W-1:0] chars_in,
    input  logic [WORD_W-1:0]       bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_W-1:0]       bin_out,
    output logic [NCHAR*BYTE_W-1:0] chars_out,
    output logic                    ovf
);

    localparam int unsigned STEP_W  = cnt_w(NCHAR, WORD_W);
    localparam int unsigned FIELD_W = NCHAR * BYTE_W;
    localparam int unsigned PROD_W  = WORD_W + 4;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [FIELD_W-1:0]  src_q, src_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [WORD_W-1:0]   bin_out_q, bin_out_d;
    logic [PROD_W-1:0]   prod;
    logic                num_last;

    // One NUM step: acc*10 + (code mod 10), kept wide to observe the carry-out.
    assign prod = PROD_W'(acc_q) * PROD_W'(10)
                + PROD_W'(mod10(CODE_W'(src_q[FIELD_W-1 -: BYTE_W])));
    assign num_last = (cnt_q == STEP_W'(NCHAR - 1));

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign bin_out = bin_out_q;

`ifdef NUM_CHAR_CONV_CHAR_EN
    logic                mode_q, mode_d;
    logic [WORD_W-1:0]   bin_sh_q, bin_sh_d;
    logic [NCHAR*4-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [FIELD_W-1:0]  chars_out_q, chars_out_d, chars_fmt;
    logic                char_last;

    for (genvar g = 0; g < NCHAR; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (bcd_q[g*4 +: 4]),
            .digit_c (bcd_adj[g*4 +: 4])
        );
    end

    assign char_last = (cnt_q == STEP_W'(WORD_W - 1));
    assign chars_out = chars_out_q;

    always_comb begin
        chars_fmt = '0;
        for (int i = 0; i < NCHAR; i++) begin
            chars_fmt[i*BYTE_W +: BYTE_W] = BYTE_W'(DIGIT_BASE) + BYTE_W'(bcd_q[i*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_NUM;
            bin_sh_q    <= '0;
            bcd_q       <= '0;
            chars_out_q <= '0;
        end else begin
            mode_q      <= mode_d;
            bin_sh_q    <= bin_sh_d;
            bcd_q       <= bcd_d;
            chars_out_q <= chars_out_d;
        end
    end
`else
    logic unused_char_inputs;
    assign unused_char_inputs = ^{mode, bin_in};
    assign chars_out = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            src_q     <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bin_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bin_out_q <= bin_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        bin_out_d = bin_out_q;
`ifdef NUM_CHAR_CONV_CHAR_EN
        mode_d      = mode_q;
        bin_sh_d    = bin_sh_q;
        bcd_d       = bcd_q;
        chars_out_d = chars_out_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    src_d     = chars_in;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    ovf_d     = 1'b0;
                    busy_d    = 1'b1;
`ifdef NUM_CHAR_CONV_CHAR_EN
                    mode_d   = mode;
                    bin_sh_d = bin_in;
                    bcd_d    = '0;
                    state_d  = (mode == MODE_CHAR) ? CHAR_RUN : NUM_RUN;
`else
                    state_d  = NUM_RUN;
`endif
                end
            end
            NUM_RUN: begin
                acc_d     = prod[WORD_W-1:0];
                ovf_acc_d = ovf_acc_q | (|prod[PROD_W-1:WORD_W]);
                src_d     = src_q << BYTE_W;
                cnt_d     = cnt_q + STEP_W'(1);
                if (num_last) state_d = FINISH;
            end
`ifdef NUM_CHAR_CONV_CHAR_EN
            // Correct every digit, then shift the next binary bit in; the top bit falls out.
            CHAR_RUN: begin
                bcd_d     = {bcd_adj[NCHAR*4-2:0], bin_sh_q[WORD_W-1]};
                ovf_acc_d = ovf_acc_q | bcd_adj[NCHAR*4-1];
                bin_sh_d  = bin_sh_q << 1;
                cnt_d     = cnt_q + STEP_W'(1);
                if (char_last) state_d = FINISH;
            end
`endif
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ovf_d   = ovf_acc_q;
                state_d = IDLE;
`ifdef NUM_CHAR_CONV_CHAR_EN
                if (mode_q == MODE_CHAR) chars_out_d = chars_fmt;
                else                     bin_out_d   = acc_q;
`else
                bin_out_d = acc_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
